// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the multi-channel servo PWM controller.
//   - Avalon word offsets of the register map and the CTRL enable bit
//   - reset/limit defaults for period and pulse width
//   - clamp_pw(): bounds a 32-bit write value into [lo, hi]
//   - decode_addr(): maps a word address onto a register kind and channel
package servo_pwm_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'd0;
    localparam logic [7:0] ADDR_PERIOD  = 8'd1;
    localparam logic [7:0] ADDR_STATUS  = 8'd2;
    localparam logic [7:0] ADDR_RSVD    = 8'd3;
    localparam logic [7:0] ADDR_CH_BASE = 8'd4;   // PW[k] at base+2k, CAP[k] at base+2k+1

    localparam int CTRL_EN_BIT = 0;

    localparam int PERIOD_DEFAULT_C = 1000000;   // 20 ms at 50 MHz
    localparam int MIN_PW_C         = 50000;     // 1 ms
    localparam int MAX_PW_C         = 100000;    // 2 ms
    localparam int SYNC_STAGES_C    = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_PERIOD,
        REG_STATUS,
        REG_PW,
        REG_CAP
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] ch;
    } reg_dec_t;

    function automatic logic [31:0] clamp_pw(input logic [31:0] value,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
        if (value < lo)
            return lo;
        if (value > hi)
            return hi;
        return value;
    endfunction

    // Channel slots beyond num_ch decode as REG_NONE so they read 0 and
    // swallow writes.
    function automatic reg_dec_t decode_addr(input logic [7:0] addr,
                                             input int         num_ch);
        reg_dec_t   d;
        logic [7:0] off;
        d.sel = REG_NONE;
        d.ch  = '0;
        off   = '0;
        case (addr)
            ADDR_CTRL:   d.sel = REG_CTRL;
            ADDR_PERIOD: d.sel = REG_PERIOD;
            ADDR_STATUS: d.sel = REG_STATUS;
            ADDR_RSVD:   d.sel = REG_NONE;
            default: begin
                off = addr - ADDR_CH_BASE;
                if (addr >= ADDR_CH_BASE && int'(off[7:1]) < num_ch) begin
                    d.sel = off[0] ? REG_CAP : REG_PW;
                    d.ch  = off[4:1];
                end
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/servo_pwm_capture.sv
// Per-channel high-time capture for a servo response input.
//   clk, reset  : system clock, asynchronous active-high reset
//   pwm_in      : asynchronous response input
//   cap_valid   : one-cycle strobe, high while a completed pulse is being latched
//   cap_value   : last measured high time in clk cycles (saturating)
// The input passes through SYNC_STAGES flops; a falling edge only produces a
// capture if a rising edge has been seen since the last capture or reset.
module servo_pwm_capture
    import servo_pwm_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = SYNC_STAGES_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic             cap_valid,
    output logic [CNT_W-1:0] cap_value
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES:0]   sync_shift;
    logic                   level;
    logic                   level_prev;
    logic                   busy;
    logic                   rise;
    logic                   fall;
    logic [CNT_W-1:0]       high_cnt;

    always_comb begin
        sync_shift = {sync, pwm_in};
        // Top bit of the shift vector is the oldest synchronised sample.
        level      = sync_shift[SYNC_STAGES];
        rise       = level & ~level_prev;
        fall       = ~level & level_prev;
        cap_valid  = fall & busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= '0;
            level_prev <= 1'b0;
            busy       <= 1'b0;
            high_cnt   <= '0;
            cap_value  <= '0;
        end else begin
            sync       <= sync_shift[SYNC_STAGES-1:0];
            level_prev <= level;

            if (rise) begin
                high_cnt <= '0;
                busy     <= 1'b1;
            end else if (level && high_cnt != CNT_MAX) begin
                high_cnt <= high_cnt + 1'b1;
            end

            // The rise cycle itself is not counted, hence the +1 on capture.
            if (cap_valid) begin
                cap_value <= (high_cnt == CNT_MAX) ? CNT_MAX : high_cnt + 1'b1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM controller with an Avalon-MM slave.
//   clk, reset      : system clock, asynchronous active-high reset
//   address, read,
//   write, writedata: Avalon-MM slave (word addressed, no waitrequest)
//   readdata        : registered read data, valid one cycle after read
//   pwm_out         : servo pulse outputs, one per channel
//   pwm_in          : asynchronous servo response inputs, one per channel
// One period counter is shared by all channels. Software writes shadow
// registers; they are copied to the active set on the period wrap (or
// continuously while disabled), so a pulse never changes width mid-period.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 20,
    parameter int PERIOD_DEFAULT = PERIOD_DEFAULT_C,
    parameter int MIN_PW         = MIN_PW_C,
    parameter int MAX_PW         = MAX_PW_C,
    parameter int SYNC_STAGES    = SYNC_STAGES_C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    input  logic [NUM_CH-1:0] pwm_in
);

    localparam logic [CNT_W-1:0] PW_MID     = CNT_W'((MIN_PW + MAX_PW) / 2);
    localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(PERIOD_DEFAULT);
    localparam logic [31:0]      PW_LO      = 32'(MIN_PW);
    localparam logic [31:0]      PW_HI      = 32'(MAX_PW);
    // A period must leave at least one low cycle after the widest pulse.
    localparam logic [31:0]      PERIOD_LO  = 32'(MAX_PW + 1);
    localparam logic [31:0]      PERIOD_HI  = 32'((64'd1 << CNT_W) - 64'd1);

    logic                   ctrl_en;
    logic [CNT_W-1:0]       period_shadow;
    logic [CNT_W-1:0]       period_active;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       pw_shadow [NUM_CH];
    logic [CNT_W-1:0]       pw_active [NUM_CH];
    logic [NUM_CH-1:0]      status;
    logic [NUM_CH-1:0]      cap_valid;
    logic [CNT_W-1:0]       cap_value [NUM_CH];

    reg_dec_t               dec;
    logic                   wr_ctrl;
    logic                   wr_period;
    logic                   wr_status;
    logic [NUM_CH-1:0]      wr_pw;
    logic                   en_next;
    logic                   wrap;
    logic [31:0]            pw_clamped;
    logic [31:0]            period_clamped;
    logic [CNT_W-1:0]       pw_wdata;
    logic [CNT_W-1:0]       period_wdata;
    logic [31:0]            rd_word;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cap
        servo_pwm_capture #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cap (
            .clk       (clk),
            .reset     (reset),
            .pwm_in    (pwm_in[k]),
            .cap_valid (cap_valid[k]),
            .cap_value (cap_value[k])
        );
    end

    always_comb begin
        dec       = decode_addr(address, NUM_CH);
        wr_ctrl   = write && (dec.sel == REG_CTRL);
        wr_period = write && (dec.sel == REG_PERIOD);
        wr_status = write && (dec.sel == REG_STATUS);
        wr_pw     = '0;
        for (int k = 0; k < NUM_CH; k++)
            wr_pw[k] = write && (dec.sel == REG_PW) && (int'(dec.ch) == k);

        pw_clamped     = clamp_pw(writedata, PW_LO, PW_HI);
        period_clamped = clamp_pw(writedata, PERIOD_LO, PERIOD_HI);
        pw_wdata       = pw_clamped[CNT_W-1:0];
        period_wdata   = period_clamped[CNT_W-1:0];

        // en_next lets a disabling write kill the output on the very next
        // cycle instead of one cycle later.
        en_next = wr_ctrl ? writedata[CTRL_EN_BIT] : ctrl_en;
        wrap    = ctrl_en && (count == period_active - 1'b1);

        rd_word = '0;
        case (dec.sel)
            REG_CTRL:   rd_word[CTRL_EN_BIT]  = ctrl_en;
            REG_PERIOD: rd_word[CNT_W-1:0]    = period_shadow;
            REG_STATUS: rd_word[NUM_CH-1:0]   = status;
            REG_PW: begin
                for (int k = 0; k < NUM_CH; k++)
                    if (int'(dec.ch) == k)
                        rd_word[CNT_W-1:0] = pw_shadow[k];
            end
            REG_CAP: begin
                for (int k = 0; k < NUM_CH; k++)
                    if (int'(dec.ch) == k)
                        rd_word[CNT_W-1:0] = cap_value[k];
            end
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en       <= 1'b0;
            period_shadow <= PERIOD_RST;
            period_active <= PERIOD_RST;
            count         <= '0;
            status        <= '0;
            readdata      <= '0;
            pwm_out       <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                pw_shadow[k] <= PW_MID;
                pw_active[k] <= PW_MID;
            end
        end else begin
            if (wr_ctrl)
                ctrl_en <= writedata[CTRL_EN_BIT];
            if (wr_period)
                period_shadow <= period_wdata;
            for (int k = 0; k < NUM_CH; k++)
                if (wr_pw[k])
                    pw_shadow[k] <= pw_wdata;

            // Non-blocking copy: a shadow write landing on the wrap cycle is
            // not seen here and takes effect one period later.
            if (!ctrl_en || wrap) begin
                period_active <= period_shadow;
                for (int k = 0; k < NUM_CH; k++)
                    pw_active[k] <= pw_shadow[k];
            end

            if (!ctrl_en || wrap)
                count <= '0;
            else
                count <= count + 1'b1;

            for (int k = 0; k < NUM_CH; k++)
                pwm_out[k] <= ctrl_en && en_next && (count < pw_active[k]);

            // Capture set takes priority over a simultaneous W1C.
            status <= cap_valid |
                      (status & ~({NUM_CH{wr_status}} & writedata[NUM_CH-1:0]));

            if (read)
                readdata <= rd_word;
        end
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised N-channel servo PWM controller with an Avalon-MM slave, for the Computer_System (HPS lightweight bridge). One shared period counter drives NUM_CH pulse outputs. Pulse-width updates are glitch-free and limited to servo-safe bounds. Each channel also captures the measured high-time of its pwm_response input.

Parameters:
NUM_CH, 4, number of PWM/capture channel pairs (1..16)
CNT_W, 20, width of the period, pulse-width and capture counters
PERIOD_DEFAULT, 1000000, reset period in clk cycles (20 ms at 50 MHz)
MIN_PW, 50000, lower pulse-width limit (1 ms)
MAX_PW, 100000, upper pulse-width limit (2 ms)
SYNC_STAGES, 2, synchroniser depth on pwm_in

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
address  in  8  word address
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
writedata  in  32  write data
readdata  out  32  read data, registered, valid 1 cycle after read
pwm_out  out  NUM_CH  servo pulse outputs
pwm_in  in  NUM_CH  asynchronous servo response inputs

Behaviour:
- Reset: pwm_out=0, readdata=0, CTRL=0, PERIOD=PERIOD_DEFAULT, all PW shadow/active=(MIN_PW+MAX_PW)/2, CAP=0, STATUS=0, counters=0, synchronisers=0.
- Register map: 0 CTRL (bit0 EN, RW); 1 PERIOD (RW); 2 STATUS (bit k = CAP[k] valid, write 1 to clear); 3 reads 0; 4+2k PW[k] (RW shadow); 5+2k CAP[k] (RO). Unmapped and k>=NUM_CH addresses read 0 and ignore writes. Upper bits beyond CNT_W read 0.
- Writes take effect the cycle after the write strobe. Reads have fixed 1-cycle latency with no waitrequest.
- PW writes are clamped on entry to [MIN_PW, MAX_PW]. PERIOD writes below MAX_PW+1 are clamped to MAX_PW+1.
- Period counter: while EN=1, counts 0..PERIOD_active-1 and wraps to 0. While EN=0, it is held at 0.
- Wrap cycle (count==PERIOD_active-1, EN=1): PW_active[k]<=PW_shadow[k] and PERIOD_active<=PERIOD. If a write lands on the same cycle, the pre-write shadow value is loaded and the new value applies from the next period.
- While EN=0: active registers track shadow every cycle and pwm_out=0.
- pwm_out[k] is registered: it is 1 in the cycle after count < PW_active[k] with EN=1. The first high cycle follows the EN 0->1 write by 2 cycles.
- EN 1->0: pwm_out drops to 0 on the next cycle, even mid-pulse. The period restarts from 0 on re-enable.
- Capture per channel: pwm_in passes through SYNC_STAGES flops.
  - Rising edge: clear the high-time counter and set busy.
  - While high: increment the counter, saturating at 2^CNT_W-1.
  - Falling edge while busy: CAP[k]<=counter+1 and set STATUS[k].
  - Falling edge without a prior rising edge since reset: ignored.
  - A new pulse overwrites CAP and keeps STATUS set.
  - If a capture set and a W1C clear hit the same bit on the same cycle, the set wins.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values and pwm_out goes to 0 the same instant.

Decomposition:
- servo_pwm_pkg holds:
  - register offset constants
  - CTRL bit index
  - default PERIOD/MIN/MAX constants
  - clamp_pw function
- One sub-module, servo_pwm_capture: synchroniser, edge detector, saturating high-time counter and capture register. It is instantiated NUM_CH times.
- The top level holds the Avalon decode, shared counter, shadow/active registers and output compare.

Test Plan:
- Reset then EN=1 with defaults -> every pwm_out shows a 75000-cycle high pulse every 1000000 cycles; first rising edge 2 cycles after the write.
- Write PW[1]=60000 mid-period -> the current period keeps 75000 and the next period is 60000. Writing exactly on the wrap cycle defers to the period after.
- Write PW[0]=10 and PW[2]=200000 -> they read back 50000 and 100000 and produce 1 ms and 2 ms pulses. Write PERIOD=5 -> reads back 100001.
- Drive pwm_in[3] high for 1234 cycles -> CAP[3]=1234 and STATUS=0x8. W1C 0x8 -> STATUS=0. W1C coinciding with a new capture -> STATUS bit stays 1.
- Hold pwm_in[0] high for longer than 2^20 cycles then drop it -> CAP[0]=0xFFFFF. A falling edge right after reset with no rising edge -> no capture.
- Assert reset during an active pulse and mid-capture -> pwm_out=0 immediately; all registers return to reset values; reading address 200 returns 0.
